// File: rtl/mult_sequencer.sv
// Multi-cycle radix-2 shift-add multiplier with HI/LO result registers.
// The sign is handled outside the loop: multiply the magnitudes, negate the product at the end.
module mult_sequencer #(
   parameter int unsigned WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start_mult,
   input  logic             mult_sign,
   input  logic [WIDTH-1:0] operand_a,
   input  logic [WIDTH-1:0] operand_b,
   input  logic             mfhi_req,
   input  logic             mflo_req,
   output logic [WIDTH-1:0] hi_out,
   output logic [WIDTH-1:0] lo_out,
   output logic             busy,
   output logic             done,
   output logic             stall
);

   localparam int unsigned CW = $clog2(WIDTH) + 1;
   localparam int unsigned PW = 2 * WIDTH;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      FIX  = 2'd2
   } state_t;

   state_t           state;
   state_t           state_nxt;
   logic             load;
   logic             step;
   logic             fix;
   logic             neg;
   logic [WIDTH-1:0] mag_a;
   logic [WIDTH-1:0] mag_b;
   logic [PW-1:0]    acc;
   logic [PW-1:0]    partial;
   logic [CW-1:0]    count;
   logic             last;

   assign last    = (count == CW'(WIDTH - 1));
   assign partial = PW'(mag_a) << count;

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start_mult) state_nxt = RUN;
         RUN:     if (last)       state_nxt = FIX;
         FIX:                     state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   // Datapath controls decoded from state
   always_comb begin
      load = 1'b0;
      step = 1'b0;
      fix  = 1'b0;
      case (state)
         IDLE:    load = start_mult;
         RUN:     step = 1'b1;
         FIX:     fix  = 1'b1;
         default: ;
      endcase
   end

   // While busy, every dependent request is held; start wins in IDLE so stall stays low there.
   assign busy  = (state != IDLE);
   assign stall = busy & (start_mult | mfhi_req | mflo_req);

   // Operand capture, shift-add iteration and sign fix-up into HI/LO
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         neg    <= 1'b0;
         mag_a  <= '0;
         mag_b  <= '0;
         acc    <= '0;
         count  <= '0;
         hi_out <= '0;
         lo_out <= '0;
         done   <= 1'b0;
      end else begin
         done <= fix;
         if (load) begin
            neg   <= mult_sign & (operand_a[WIDTH-1] ^ operand_b[WIDTH-1]);
            mag_a <= (mult_sign && operand_a[WIDTH-1]) ? -operand_a : operand_a;
            mag_b <= (mult_sign && operand_b[WIDTH-1]) ? -operand_b : operand_b;
            acc   <= '0;
            count <= '0;
         end
         if (step) begin
            if (mag_b[0]) acc <= acc + partial;
            mag_b <= mag_b >> 1;
            count <= count + CW'(1);
         end
         if (fix) begin
            {hi_out, lo_out} <= neg ? -acc : acc;
         end
      end
   end

endmodule

// File: tb/tb_mult_sequencer.sv
// Self-checking bench for mult_sequencer: vector table plus scoreboard of expected HI/LO products.
module tb_mult_sequencer;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        start_mult = 1'b0;
   logic        mult_sign = 1'b0;
   logic [31:0] operand_a = '0;
   logic [31:0] operand_b = '0;
   logic        mfhi_req = 1'b0;
   logic        mflo_req = 1'b0;
   logic [31:0] hi_out;
   logic [31:0] lo_out;
   logic        busy;
   logic        done;
   logic        stall;

   int errors = 0;
   int checks = 0;
   logic [63:0] sb[$];

   typedef struct {
      bit          s;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] hi;
      logic [31:0] lo;
   } vec_t;
   vec_t vecs[9];

   mult_sequencer #(.WIDTH(32)) dut (
      .clk(clk), .rst_n(rst_n), .start_mult(start_mult), .mult_sign(mult_sign),
      .operand_a(operand_a), .operand_b(operand_b), .mfhi_req(mfhi_req), .mflo_req(mflo_req),
      .hi_out(hi_out), .lo_out(lo_out), .busy(busy), .done(done), .stall(stall)
   );

   always #5 clk = ~clk;

   function automatic logic [63:0] model(input bit s, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] sa;
      logic signed [63:0] sbv;
      if (s) begin
         sa  = {{32{a[31]}}, a};
         sbv = {{32{b[31]}}, b};
         return 64'(sa * sbv);
      end
      return {32'd0, a} * {32'd0, b};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Present a multiply for exactly one edge (E0), then scramble the operand inputs.
   task automatic start_op(input bit s, input logic [31:0] a, input logic [31:0] b,
                           input logic [63:0] exp);
      @(posedge clk); #1;
      mult_sign = s; operand_a = a; operand_b = b; start_mult = 1'b1;
      sb.push_back(exp);
      @(posedge clk); #1;
      start_mult = 1'b0; operand_a = $urandom; operand_b = $urandom; mult_sign = 1'($urandom);
   endtask

   // mode 0: plain; 1: raise mfhi_req after sample raise_at; 2: re-present start_mult then
   task automatic wait_done(input int exp_busy, input int raise_at, input int mode,
                            input logic [63:0] exp2);
      int          busy_cnt = 0;
      int          stall_bad = 0;
      int          hold_bad = 0;
      bit          got = 0;
      logic [31:0] ph = hi_out;
      logic [31:0] pl = lo_out;
      logic [63:0] e;
      for (int n = 1; n <= 100 && !got; n++) begin
         @(negedge clk);
         if (done) begin
            got = 1;
            chk("busy_cycles", 64'(busy_cnt), 64'(exp_busy));
            chk("busy_in_done", 64'(busy), 64'd0);
            chk("stall_in_done", 64'(stall), 64'd0);
            if (sb.size() == 0) begin
               checks++; errors++;
               $display("FAIL scoreboard: got done with no expected result queued");
            end else begin
               e = sb.pop_front();
               chk("hi_out", 64'(hi_out), 64'(e[63:32]));
               chk("lo_out", 64'(lo_out), 64'(e[31:0]));
            end
            chk("hold_during_run", 64'(hold_bad), 64'd0);
            chk("stall_during_run", 64'(stall_bad), 64'd0);
            mfhi_req = 1'b0;
         end else begin
            if (busy) busy_cnt++;
            if (hi_out !== ph || lo_out !== pl) hold_bad++;
            if (stall !== (raise_at != 0 && n > raise_at)) stall_bad++;
            if (n == raise_at && mode == 1) mfhi_req = 1'b1;
            if (n == raise_at && mode == 2) begin
               start_mult = 1'b1; mult_sign = 1'b0;
               operand_a = 32'd7; operand_b = 32'd9;
            end
         end
      end
      if (!got) chk("done_timeout", 64'd0, 64'd1);
      if (mode == 2) begin
         sb.push_back(exp2);
         @(posedge clk); #1;
         start_mult = 1'b0; operand_a = $urandom; operand_b = $urandom;
      end
      @(negedge clk);
      chk("done_single_pulse", 64'(done), 64'd0);
      if (mode == 2) chk("second_op_started", 64'(busy), 64'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] ra;
      logic [31:0] rb;
      bit          rs;
      int          bad;

      vecs[0] = '{1'b0, 32'h00000003, 32'h00000005, 32'h00000000, 32'h0000000F};
      vecs[1] = '{1'b1, 32'hFFFFFFFD, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFF1};
      vecs[2] = '{1'b0, 32'hFFFFFFFD, 32'h00000005, 32'h00000004, 32'hFFFFFFF1};
      vecs[3] = '{1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001};
      vecs[4] = '{1'b1, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000};
      vecs[5] = '{1'b1, 32'h00000000, 32'h80000000, 32'h00000000, 32'h00000000};
      vecs[6] = '{1'b1, 32'h00000007, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9};
      vecs[7] = '{1'b1, 32'h80000000, 32'h00000001, 32'hFFFFFFFF, 32'h80000000};
      vecs[8] = '{1'b1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000001};

      #1 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_hi", 64'(hi_out), 64'd0);
      chk("rst_lo", 64'(lo_out), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_stall", 64'(stall), 64'd0);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         start_op(vecs[i].s, vecs[i].a, vecs[i].b, {vecs[i].hi, vecs[i].lo});
         wait_done(33, 0, 0, 64'd0);
      end

      for (int i = 0; i < 4; i++) begin
         ra = $urandom; rb = $urandom; rs = 1'($urandom);
         start_op(rs, ra, rb, model(rs, ra, rb));
         wait_done(33, 0, 0, 64'd0);
      end

      // MFHI arrives mid-run: stalled until busy falls, then reads the fresh HI
      start_op(1'b0, 32'h12345678, 32'h00000100, 64'h00000012_34567800);
      wait_done(33, 10, 1, 64'd0);

      // Second MULTU held behind the first; it must start on the edge after done
      start_op(1'b0, 32'h0000FFFF, 32'h00010001, 64'h00000000_FFFFFFFF);
      wait_done(33, 5, 2, 64'd63);
      wait_done(32, 0, 0, 64'd0);

      // Reset in the middle of a run aborts it with no HI/LO write
      start_op(1'b1, 32'hFFFFFFF0, 32'h00000003, 64'hFFFFFFFF_FFFFFFD0);
      void'(sb.pop_front());
      repeat (12) @(negedge clk);
      chk("pre_abort_lo", 64'(lo_out), 64'd63);
      rst_n = 1'b0;
      #1;
      chk("abort_hi", 64'(hi_out), 64'd0);
      chk("abort_lo", 64'(lo_out), 64'd0);
      chk("abort_busy", 64'(busy), 64'd0);
      chk("abort_done", 64'(done), 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      bad = 0;
      repeat (40) begin
         @(negedge clk);
         if (done !== 1'b0 || busy !== 1'b0 || lo_out !== 32'd0) bad++;
      end
      chk("no_done_after_abort", 64'(bad), 64'd0);

      start_op(1'b0, 32'h00000003, 32'h00000005, 64'h00000000_0000000F);
      wait_done(33, 0, 0, 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
